// File: rtl/adc_scheduler.sv
// adc_scheduler: round-robin ADC channel scheduler with settle/convert timing and result handshake.
// Define ADC_SCHEDULER_AVG_EN to average four conversions per grant.
module adc_scheduler #(
  parameter int FINE_BITS     = 9,
  parameter int NUM_CH        = 3,
  parameter int SETTLE_CYCLES = 16,
  parameter int CONV_TIMEOUT  = 4096
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_CH-1:0]  ch_req,
  output logic [1:0]         ch_sel,
  output logic               adc_reset,
  input  logic               adc_valid,
  input  logic [FINE_BITS:0] adc_data,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [FINE_BITS:0] res_data,
  output logic [1:0]         res_ch,
  output logic               res_timeout,
  output logic               busy
);
  localparam int DW   = FINE_BITS + 1;
  localparam int CMAX = SETTLE_CYCLES > CONV_TIMEOUT ? SETTLE_CYCLES : CONV_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  typedef enum logic [2:0] {IDLE, SELECT, SETTLE, CONVERT, DELIVER} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    last_q, last_d, ch_sel_q, ch_sel_d, res_ch_q, res_ch_d, win, idx;
  logic          adc_reset_q, adc_reset_d, res_valid_q, res_valid_d;
  logic          res_timeout_q, res_timeout_d, busy_q, busy_d;
  logic [DW-1:0] res_data_q, res_data_d;
`ifdef ADC_SCHEDULER_AVG_EN
  logic [1:0]    pass_q, pass_d;
  logic [DW+1:0] sum_q, sum_d;
`endif
  assign ch_sel      = ch_sel_q;
  assign adc_reset   = adc_reset_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_ch      = res_ch_q;
  assign res_timeout = res_timeout_q;
  assign busy        = busy_q;
  // Scan downward so the nearest requester after last_q is written last and wins.
  always_comb begin
    win = last_q;
    idx = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = 2'((32'(last_q) + 32'(k)) % NUM_CH);
      if (ch_req[idx]) win = idx;
    end
  end
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
    ch_sel_d      = ch_sel_q;
    res_ch_d      = res_ch_q;
    res_data_d    = res_data_q;
    res_timeout_d = res_timeout_q;
`ifdef ADC_SCHEDULER_AVG_EN
    pass_d        = pass_q;
    sum_d         = sum_q;
`endif
    case (state_q)
      IDLE: if (|ch_req) begin
        state_d  = SELECT;
        ch_sel_d = win;
`ifdef ADC_SCHEDULER_AVG_EN
        pass_d   = '0;
        sum_d    = '0;
`endif
      end
      SELECT: begin
        state_d = SETTLE;
        cnt_d   = '0;
      end
      SETTLE: if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
        state_d = CONVERT;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 1'b1;
      CONVERT: if (adc_valid) begin
`ifdef ADC_SCHEDULER_AVG_EN
        sum_d = sum_q + {2'b00, adc_data};
        if (pass_q == 2'd3) begin
          state_d       = DELIVER;
          res_data_d    = sum_d[DW+1:2];
          res_timeout_d = 1'b0;
          res_ch_d      = ch_sel_q;
        end else begin
          state_d = SELECT;
          pass_d  = pass_q + 1'b1;
        end
`else
        state_d       = DELIVER;
        res_data_d    = adc_data;
        res_timeout_d = 1'b0;
        res_ch_d      = ch_sel_q;
`endif
      end else if (cnt_q == CW'(CONV_TIMEOUT - 1)) begin
        state_d       = DELIVER;
        res_data_d    = '0;
        res_timeout_d = 1'b1;
        res_ch_d      = ch_sel_q;
      end else cnt_d = cnt_q + 1'b1;
      DELIVER: if (res_ready) begin
        state_d = IDLE;
        last_d  = ch_sel_q;
      end
      default: state_d = IDLE;
    endcase
    adc_reset_d = state_d == SELECT;
    res_valid_d = state_d == DELIVER;
    busy_d      = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      last_q        <= 2'(NUM_CH - 1);
      ch_sel_q      <= '0;
      res_ch_q      <= '0;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
      adc_reset_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
`ifdef ADC_SCHEDULER_AVG_EN
      pass_q        <= '0;
      sum_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      ch_sel_q      <= ch_sel_d;
      res_ch_q      <= res_ch_d;
      res_data_q    <= res_data_d;
      res_timeout_q <= res_timeout_d;
      adc_reset_q   <= adc_reset_d;
      res_valid_q   <= res_valid_d;
      busy_q        <= busy_d;
`ifdef ADC_SCHEDULER_AVG_EN
      pass_q        <= pass_d;
      sum_q         <= sum_d;
`endif
    end
  end
endmodule
